// File: rtl/pwm_pkg.sv
// Constants and state encoding shared by the PWM generator and capture blocks.
package pwm_pkg;

    typedef enum logic {
        ST_SEEK = 1'b0,
        ST_RUN  = 1'b1
    } pwm_state_t;

    localparam int PCT_SCALE = 100;
    localparam int PCT_W     = 7;

    // A high time longer than the period can only come from a glitched input; pin it at 100 %.
    function automatic logic [PCT_W-1:0] pct_clamp(input logic [31:0] q);
        if (q > 32'(PCT_SCALE)) begin
            return PCT_W'(PCT_SCALE);
        end
        return q[PCT_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider: one quotient bit per cycle, DIV_W iterations.
// done/quotient show the final iteration combinationally so the caller can register it directly.
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DIV_W = CNT_W + PCT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    localparam int IT_W = $clog2(DIV_W + 1);

    logic             busy_q, busy_d;
    logic [IT_W-1:0]  iter_q, iter_d;
    logic [CNT_W:0]   rem_q, rem_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] dvs_q, dvs_d;

    logic [CNT_W:0]   rem_sh;
    logic [CNT_W:0]   rem_sub;
    logic             ge;

    assign rem_sh  = {rem_q[CNT_W-1:0], quo_q[DIV_W-1]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign ge      = rem_q[CNT_W] | (rem_sh >= {1'b0, dvs_q});

    always_comb begin
        busy_d = busy_q;
        iter_d = iter_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start && !busy_q) begin
            busy_d = 1'b1;
            iter_d = IT_W'(DIV_W);
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
        end else if (busy_q) begin
            rem_d  = ge ? rem_sub : rem_sh;
            quo_d  = {quo_q[DIV_W-2:0], ge};
            iter_d = iter_q - IT_W'(1);
            if (iter_q == IT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            iter_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            iter_q <= iter_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (iter_q == IT_W'(1));
    // A zero divisor would otherwise yield all ones.
    assign quotient = (dvs_q == '0) ? '0 : {quo_q[DIV_W-2:0], ge};

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and duty of an asynchronous PWM input; flags an edgeless input.
//   state   | meaning
//   ST_SEEK | waiting for a rising edge to arm the timebase (after reset or stuck)
//   ST_RUN  | armed; each rising edge closes one period and may start a duty divide
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] per_cnt,
    output logic [CNT_W-1:0] hi_cnt,
    output logic [PCT_W-1:0] duty_pct,
    output logic             meas_valid,
    output logic             busy,
    output logic             drop,
    output logic             stuck,
    output logic             stuck_level
);

    localparam int               DIV_W   = CNT_W + PCT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

    pwm_state_t       state_q, state_d;
    logic             sync1_q, s_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [PCT_W-1:0] duty_q, duty_d;
    logic             meas_valid_q, meas_valid_d;
    logic             drop_q, drop_d;
    logic             stuck_q, stuck_d;
    logic             stuck_level_q, stuck_level_d;

    logic             rise, fall, tmo;
    logic             div_start, div_abort, div_busy, div_done;
    logic [DIV_W-1:0] div_dividend, div_quotient;

    assign rise = s_q & ~prev_q;
    assign fall = ~s_q & prev_q;
    // A rise in the timeout cycle restarts the timebase, so it takes priority.
    assign tmo  = ~rise && (cnt_q == TMO);

    assign div_dividend = DIV_W'(hi_lat_q) * DIV_W'(PCT_SCALE);

    pwm_duty_div #(
        .CNT_W (CNT_W),
        .DIV_W (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (div_dividend),
        .divisor  (cnt_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_comb begin
        state_d       = state_q;
        hi_lat_d      = hi_lat_q;
        per_cnt_d     = per_cnt_q;
        hi_cnt_d      = hi_cnt_q;
        duty_d        = duty_q;
        meas_valid_d  = 1'b0;
        drop_d        = 1'b0;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;
        div_start     = 1'b0;
        div_abort     = 1'b0;

        cnt_d = rise ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));

        if (fall) begin
            hi_lat_d = cnt_q;
        end

        if (div_done) begin
            duty_d       = pct_clamp(32'(div_quotient));
            meas_valid_d = 1'b1;
        end

        if (rise) begin
            stuck_d = 1'b0;
            if (state_q == ST_SEEK) begin
                state_d = ST_RUN;
            end else if (div_busy) begin
                drop_d = 1'b1;
            end else begin
                per_cnt_d = cnt_q;
                hi_cnt_d  = hi_lat_q;
                div_start = 1'b1;
            end
        end else if (tmo) begin
            stuck_d       = 1'b1;
            stuck_level_d = s_q;
            per_cnt_d     = '0;
            hi_cnt_d      = '0;
            duty_d        = s_q ? PCT_W'(PCT_SCALE) : '0;
            meas_valid_d  = 1'b1;
            div_abort     = 1'b1;
            state_d       = ST_SEEK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SEEK;
            sync1_q       <= 1'b0;
            s_q           <= 1'b0;
            prev_q        <= 1'b0;
            cnt_q         <= '0;
            hi_lat_q      <= '0;
            per_cnt_q     <= '0;
            hi_cnt_q      <= '0;
            duty_q        <= '0;
            meas_valid_q  <= 1'b0;
            drop_q        <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= pwm_in;
            s_q           <= sync1_q;
            prev_q        <= s_q;
            cnt_q         <= cnt_d;
            hi_lat_q      <= hi_lat_d;
            per_cnt_q     <= per_cnt_d;
            hi_cnt_q      <= hi_cnt_d;
            duty_q        <= duty_d;
            meas_valid_q  <= meas_valid_d;
            drop_q        <= drop_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign per_cnt     = per_cnt_q;
    assign hi_cnt      = hi_cnt_q;
    assign duty_pct    = duty_q;
    assign meas_valid  = meas_valid_q;
    assign busy        = div_busy;
    assign drop        = drop_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model checked every cycle, plus directed literal checks.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;
    localparam int LAT     = CNT_W + 8;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [6:0]       duty_pct;
    logic             meas_valid, busy, drop, stuck, stuck_level;

    always #5 clk = ~clk;

    pwm_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .per_cnt     (per_cnt),
        .hi_cnt      (hi_cnt),
        .duty_pct    (duty_pct),
        .meas_valid  (meas_valid),
        .busy        (busy),
        .drop        (drop),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: event timestamps in cycles, durations by subtraction, duty by integer divide.
    int t = 0, base = 0, armed = 0, hi_lat = 0;
    int acc_t = 0, acc_v = 0, res_duty = 0;
    int e_per = 0, e_hi = 0, e_duty = 0, e_stuck = 0, e_lvl = 0, e_mv = 0, e_drop = 0;
    int sm = 0, pm = 0, x1 = 0;
    int el, bsy;
    bit rise_m, fall_m;

    always @(negedge clk) begin
        t++;
        if (rst) begin
            base = t + 1; armed = 0; hi_lat = 0; acc_v = 0;
            e_per = 0; e_hi = 0; e_duty = 0; e_stuck = 0; e_lvl = 0; e_mv = 0; e_drop = 0;
            sm = 0; pm = 0; x1 = 0;
        end
        bsy = (acc_v != 0 && t > acc_t && t < acc_t + LAT) ? 1 : 0;
        check("per_cnt", per_cnt, e_per);
        check("hi_cnt", hi_cnt, e_hi);
        check("duty_pct", duty_pct, e_duty);
        check("meas_valid", meas_valid, e_mv);
        check("busy", busy, bsy);
        check("drop", drop, e_drop);
        check("stuck", stuck, e_stuck);
        check("stuck_level", stuck_level, e_lvl);
        if (!rst) begin
            rise_m = (sm == 1 && pm == 0);
            fall_m = (sm == 0 && pm == 1);
            el = t - base;
            if (el > CMAX) el = CMAX;
            e_mv = 0;
            e_drop = 0;
            if (acc_v != 0 && t + 1 == acc_t + LAT) begin
                e_duty = res_duty;
                e_mv = 1;
            end
            if (fall_m) hi_lat = el;
            if (rise_m) begin
                e_stuck = 0;
                base = t;
                if (armed == 0) begin
                    armed = 1;
                end else if (bsy != 0) begin
                    e_drop = 1;
                end else begin
                    e_per = el;
                    e_hi = hi_lat;
                    acc_t = t;
                    acc_v = 1;
                    res_duty = (el == 0) ? 0 : (hi_lat * 100) / el;
                    if (res_duty > 100) res_duty = 100;
                end
            end else if (el == TIMEOUT) begin
                e_stuck = 1; e_lvl = sm; e_per = 0; e_hi = 0;
                e_duty = (sm != 0) ? 100 : 0;
                e_mv = 1; acc_v = 0; armed = 0;
            end
            pm = sm;
            sm = x1;
            x1 = int'(pwm_in);
        end
    end

    // Event monitor feeding the directed checks.
    int mv_cnt = 0, drop_cnt = 0, stuck_cyc = 0, nonmono = 0, mon_prev = 0;
    int l_per = 0, l_hi = 0, l_duty = 0;
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (meas_valid) begin
                mv_cnt++;
                l_per = per_cnt; l_hi = hi_cnt; l_duty = duty_pct;
                if (mon_en && int'(duty_pct) < mon_prev) nonmono++;
                mon_prev = duty_pct;
            end
            if (drop) drop_cnt++;
            if (stuck) stuck_cyc++;
        end
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            pwm_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pwm(input int per, input int hi, input int n);
        repeat (n) begin
            drive(1'b1, hi);
            drive(1'b0, per - hi);
        end
    endtask

    task automatic clr();
        mv_cnt = 0; drop_cnt = 0; stuck_cyc = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: period 100, high 25
        clr();
        pwm(100, 25, 6);
        check("t1_mv_count", mv_cnt, 5);
        check("t1_per", l_per, 100);
        check("t1_hi", l_hi, 25);
        check("t1_duty", l_duty, 25);

        // 2: period 3, high 1 -> one capture per 8 rises
        clr();
        pwm(3, 1, 40);
        drive(1'b0, 40);
        check("t2_mv_count", mv_cnt, 5);
        check("t2_drop_count", drop_cnt, 35);
        check("t2_per", l_per, 3);
        check("t2_hi", l_hi, 1);
        check("t2_duty", l_duty, 33);

        // 3: 40 % then held low
        clr();
        pwm(50, 20, 4);
        drive(1'b0, TIMEOUT + 20);
        check("t3_mv_count", mv_cnt, 5);
        check("t3_stuck", stuck, 1);
        check("t3_level", stuck_level, 0);
        check("t3_duty", duty_pct, 0);
        check("t3_per", per_cnt, 0);
        clr();
        drive(1'b0, 200);
        check("t3_no_more_mv", mv_cnt, 0);
        check("t3_still_stuck", stuck, 1);

        // 4: held high from reset, then resume 50 %
        rst = 1'b1;
        drive(1'b1, 3);
        rst = 1'b0;
        drive(1'b1, 1100);
        check("t4_stuck", stuck, 1);
        check("t4_level", stuck_level, 1);
        check("t4_duty", duty_pct, 100);
        check("t4_hi", hi_cnt, 0);
        clr();
        pwm(100, 50, 4);
        check("t4_cleared", stuck, 0);
        check("t4_mv_count", mv_cnt, 2);
        check("t4_duty50", l_duty, 50);
        check("t4_per", l_per, 100);
        check("t4_hi50", l_hi, 50);

        // 5: reset mid-divide
        pwm(100, 30, 1);
        drive(1'b1, 10);
        check("t5_busy_before", busy, 1);
        check("t5_per_before", per_cnt, 100);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_per", per_cnt, 0);
        check("t5_rst_hi", hi_cnt, 0);
        check("t5_rst_duty", duty_pct, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_mv", meas_valid, 0);
        check("t5_rst_stuck", stuck, 0);
        pwm_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clr();
        pwm(100, 30, 1);
        check("t5_first_rise_no_mv", mv_cnt, 0);

        // 6: generator loopback, duty ramp 5..95
        clr();
        pwm(100, 5, 1);
        mon_prev = 0;
        mon_en = 1'b1;
        pwm(100, 5, 2);
        for (int d = 10; d <= 95; d += 5) pwm(100, d, 3);
        drive(1'b0, 50);
        mon_en = 1'b0;
        check("t6_mv_count", mv_cnt, 57);
        check("t6_drops", drop_cnt, 0);
        check("t6_stuck_cycles", stuck_cyc, 0);
        check("t6_monotonic", nonmono, 0);
        check("t6_final_duty", l_duty, 95);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
